// File: rtl/merger_sync_controller_pkg.sv
// Shared definitions for the merger synchronisation controller: state and
// error encodings, default widths and a small one-hot helper.
package merger_sync_controller_pkg;

   localparam int EVID_W_DEFAULT = 8;
   localparam int TMO_W_DEFAULT  = 16;
   localparam int NUM_WEDGES     = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2,
      ST_ERROR   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_ID       = 2'd1,
      ERR_DUP      = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } err_t;

   // Isolates the lowest set bit: the reported wedge when several offend at once.
   function automatic logic [NUM_WEDGES-1:0] lowest_onehot(input logic [NUM_WEDGES-1:0] v);
      return v & (~v + {{(NUM_WEDGES-1){1'b0}}, 1'b1});
   endfunction

endpackage

// File: rtl/merger_evid_compare.sv
// Per-wedge comparison of the packed end-event IDs against a reference ID.
module merger_evid_compare
   import merger_sync_controller_pkg::*;
#(
   parameter int EVID_W = EVID_W_DEFAULT
) (
   input  logic [NUM_WEDGES*EVID_W-1:0] ee_evid,
   input  logic [EVID_W-1:0]            ref_id,
   output logic [NUM_WEDGES-1:0]        mismatch
);

   for (genvar i = 0; i < NUM_WEDGES; i++) begin : g_lane
      assign mismatch[i] = (ee_evid[i*EVID_W +: EVID_W] != ref_id);
   end

endmodule

// File: rtl/merger_sync_controller.sv
// Tracks end-events from the enabled wedges, checks they belong to one event,
// and flags loss of synchronisation (ID mismatch, duplicate, timeout).
module merger_sync_controller
   import merger_sync_controller_pkg::*;
#(
   parameter int EVID_W = EVID_W_DEFAULT,
   parameter int TMO_W  = TMO_W_DEFAULT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [3:0]            wedge_enable_cfg,
   input  logic [TMO_W-1:0]      timeout_limit,
   input  logic [3:0]            ee_seen,
   input  logic [4*EVID_W-1:0]   ee_evid,
   input  logic                  clear_error,
   output logic [3:0]            wedge_enable,
   output logic                  lost_sync_reg,
   output logic [1:0]            error_code,
   output logic [3:0]            error_wedge,
   output logic [15:0]           event_count,
   output logic                  busy
);

   localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

   state_t             state;
   logic [3:0]         seen_mask;
   logic [EVID_W-1:0]  ref_id;
   logic [TMO_W-1:0]   tmo_count;

   logic               collecting;
   logic [3:0]         hits;
   logic [3:0]         dup;
   logic [3:0]         mism;
   logic [3:0]         mismatch;
   logic [3:0]         new_mask;
   logic               complete;
   logic               timed_out;
   logic [EVID_W-1:0]  entry_id;
   logic [EVID_W-1:0]  cmp_ref;
   err_t               err_code;
   logic [3:0]         err_wedge;

   assign collecting = (state == ST_COLLECT);
   assign hits       = ee_seen & wedge_enable;
   // Outside COLLECT the event starts this cycle, so its lowest wedge is the reference.
   assign cmp_ref    = collecting ? ref_id : entry_id;
   assign dup        = collecting ? (hits & seen_mask) : 4'b0000;
   assign mism       = hits & mismatch;
   assign new_mask   = (collecting ? seen_mask : 4'b0000) | hits;
   assign complete   = (hits != 4'b0000) && (new_mask == wedge_enable);
   assign timed_out  = collecting && (timeout_limit != '0) && (tmo_count == timeout_limit);

   merger_evid_compare #(.EVID_W(EVID_W)) u_compare (
      .ee_evid  (ee_evid),
      .ref_id   (cmp_ref),
      .mismatch (mismatch)
   );

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      entry_id = '0;
      for (int i = 3; i >= 0; i--) begin
         if (hits[i]) entry_id = ee_evid[i*EVID_W +: EVID_W];
      end
   end

   always_comb begin
      err_code  = ERR_NONE;
      err_wedge = 4'b0000;
      if (dup != 4'b0000) begin
         err_code  = ERR_DUP;
         err_wedge = lowest_onehot(dup);
      end else if (mism != 4'b0000) begin
         err_code  = ERR_ID;
         err_wedge = lowest_onehot(mism);
      end else if (timed_out && !complete) begin
         err_code  = ERR_TIMEOUT;
         err_wedge = lowest_onehot(wedge_enable & ~new_mask);
      end
   end

   // NOTE: state registers use non-blocking assignments only; reset is synchronous to clock.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_IDLE;
         wedge_enable  <= 4'b0000;
         lost_sync_reg <= 1'b0;
         error_code    <= ERR_NONE;
         error_wedge   <= 4'b0000;
         event_count   <= 16'd0;
         busy          <= 1'b0;
         seen_mask     <= 4'b0000;
         ref_id        <= '0;
         tmo_count     <= '0;
      end else if (state == ST_ERROR) begin
         if (clear_error) begin
            state         <= ST_IDLE;
            lost_sync_reg <= 1'b0;
            error_code    <= ERR_NONE;
            error_wedge   <= 4'b0000;
            busy          <= 1'b0;
         end
      end else if (err_code != ERR_NONE) begin
         state         <= ST_ERROR;
         lost_sync_reg <= 1'b1;
         error_code    <= err_code;
         error_wedge   <= err_wedge;
         busy          <= 1'b1;
         seen_mask     <= 4'b0000;
         tmo_count     <= '0;
      end else if (complete) begin
         state       <= ST_DONE;
         event_count <= event_count + 16'd1;
         seen_mask   <= 4'b0000;
         tmo_count   <= '0;
         busy        <= 1'b1;
      end else if (collecting) begin
         seen_mask <= new_mask;
         if (!(&tmo_count)) tmo_count <= tmo_count + TMO_ONE;
      end else if (hits != 4'b0000) begin
         state     <= ST_COLLECT;
         seen_mask <= hits;
         ref_id    <= entry_id;
         tmo_count <= '0;
         busy      <= 1'b1;
      end else begin
         // The applied mask only follows the configuration while fully idle.
         if (state == ST_IDLE) wedge_enable <= wedge_enable_cfg;
         state <= ST_IDLE;
         busy  <= 1'b0;
      end
   end

endmodule
